// File: rtl/regfile_wb_arbiter_if.sv
// Bus between the execute/memory result producers, the issue stage and the
// register-file write-side arbiter. The arbiter takes the slave side.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LQ_DEPTH = 4
);
  // ALU result path (always accepted)
  logic                        alu_valid;
  logic [ADDR_W-1:0]           alu_addr;
  logic [DATA_W-1:0]           alu_data;

  // Long-latency result path (valid/ready)
  logic                        lu_valid;
  logic                        lu_ready;
  logic [ADDR_W-1:0]           lu_addr;
  logic [DATA_W-1:0]           lu_data;

  // Issue-stage reservation and hazard queries
  logic                        issue_mark;
  logic [ADDR_W-1:0]           issue_addr;
  logic [ADDR_W-1:0]           query_rs;
  logic [ADDR_W-1:0]           query_rt;
  logic                        rs_busy;
  logic                        rt_busy;

  // Register-file write port
  logic                        RegWrite;
  logic [ADDR_W-1:0]           WriteAddr;
  logic [DATA_W-1:0]           WriteData;

  // Long-latency FIFO occupancy
  logic [$clog2(LQ_DEPTH):0]   lq_count;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lu_valid, lu_addr, lu_data,
    input  lu_ready,
    output issue_mark, issue_addr, query_rs, query_rt,
    input  rs_busy, rt_busy,
    input  RegWrite, WriteAddr, WriteData,
    input  lq_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lu_valid, lu_addr, lu_data,
    output lu_ready,
    input  issue_mark, issue_addr, query_rs, query_rt,
    output rs_busy, rt_busy,
    output RegWrite, WriteAddr, WriteData,
    output lq_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-side initiator for the register file. Merges the single-cycle ALU
// result with long-latency results (buffered in a small in-order FIFO) onto
// the one regfile write port, and tracks which destinations still have a
// write outstanding so issue can stall on rs/rt hazards.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LQ_DEPTH = 4
) (
  input logic                  clock,
  input logic                  reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int PtrW    = $clog2(LQ_DEPTH);
  localparam int CntW    = PtrW + 1;
  localparam int NumRegs = 2 ** ADDR_W;

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] addrMem [LQ_DEPTH];
  logic [DATA_W-1:0] dataMem [LQ_DEPTH];
  logic [PtrW-1:0]   rdPtr;
  logic [PtrW-1:0]   wrPtr;
  logic [CntW-1:0]   count;

  // Registered write port
  logic              regWrite;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeData;

  // Pending-write scoreboard, bit 0 never set
  logic [NumRegs-1:0] pending;
  logic [NumRegs-1:0] pendingNext;

  logic lqFull;
  logic lqEmpty;
  logic luReady;
  logic aluTake;
  logic lqPop;
  logic lqPush;

  // Select this cycle's writer: a real ALU result wins, else drain the FIFO head
  always_comb begin
    lqFull  = (count == CntW'(LQ_DEPTH));
    lqEmpty = (count == '0);
    luReady = !reset && !lqFull;
    aluTake = bus.alu_valid && (bus.alu_addr != '0);
    lqPop   = !aluTake && !lqEmpty;
    lqPush  = bus.lu_valid && luReady && (bus.lu_addr != '0);
  end

  // Register the selected write so the regfile sees it one clock after selection
  always_ff @(posedge clock) begin
    if (reset) begin
      regWrite  <= 1'b0;
      writeAddr <= '0;
      writeData <= '0;
    end else if (aluTake) begin
      regWrite  <= 1'b1;
      writeAddr <= bus.alu_addr;
      writeData <= bus.alu_data;
    end else if (lqPop) begin
      regWrite  <= 1'b1;
      writeAddr <= addrMem[rdPtr];
      writeData <= dataMem[rdPtr];
    end else begin
      regWrite  <= 1'b0;
      writeAddr <= '0;
      writeData <= '0;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (lqPush) begin
        wrPtr <= wrPtr + PtrW'(1);
      end
      if (lqPop) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      case ({lqPush, lqPop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO payload storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clock) begin
    if (lqPush) begin
      addrMem[wrPtr] <= bus.lu_addr;
      dataMem[wrPtr] <= bus.lu_data;
    end
  end

  // Scoreboard update: clear on commit, then a new reservation overrides the clear
  always_comb begin
    pendingNext = pending;
    if (regWrite) begin
      pendingNext[writeAddr] = 1'b0;
    end
    if (bus.issue_mark && (bus.issue_addr != '0)) begin
      pendingNext[bus.issue_addr] = 1'b1;
    end
    pendingNext[0] = 1'b0;
  end

  // Scoreboard state register
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pendingNext;
    end
  end

  assign bus.lu_ready  = luReady;
  assign bus.RegWrite  = regWrite;
  assign bus.WriteAddr = writeAddr;
  assign bus.WriteData = writeData;
  assign bus.lq_count  = count;
  assign bus.rs_busy   = pending[bus.query_rs];
  assign bus.rt_busy   = pending[bus.query_rt];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for the regfile write-side arbiter. Directed stimulus pushes each
// expected regfile write into a queue; a monitor pops and compares whenever
// RegWrite is seen. Occupancy, ready and busy flags are checked directly.
module tb_regfile_wb_arbiter;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clock;
  logic reset;
  int   testsRun;
  int   failCount;
  wr_t  expQ[$];
  wr_t  expWr;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .LQ_DEPTH(4)) bus ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .LQ_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard bound on simulation time
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  // Monitor: every write the DUT presents must match the head of the expected queue
  always @(negedge clock) begin
    if (bus.RegWrite === 1'b1) begin
      testsRun++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL unexpectedWrite: got addr=%0d data=%h, required no write",
                 bus.WriteAddr, bus.WriteData);
      end else begin
        expWr = expQ.pop_front();
        if (bus.WriteAddr !== expWr.addr || bus.WriteData !== expWr.data) begin
          failCount++;
          $display("[TB] FAIL regWrite: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.WriteAddr, bus.WriteData, expWr.addr, expWr.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expectWrite(input logic [4:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    expQ.push_back(w);
  endtask

  task automatic applyStimulus(
    input logic aluV, input logic [4:0] aluA, input logic [31:0] aluD,
    input logic luV,  input logic [4:0] luA,  input logic [31:0] luD,
    input logic mark, input logic [4:0] markA
  );
    bus.alu_valid  = aluV;
    bus.alu_addr   = aluA;
    bus.alu_data   = aluD;
    bus.lu_valid   = luV;
    bus.lu_addr    = luA;
    bus.lu_data    = luD;
    bus.issue_mark = mark;
    bus.issue_addr = markA;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    reset     = 1'b1;
    bus.query_rs = 5'd0;
    bus.query_rt = 5'd0;
    applyIdle();

    // Reset state
    tick();
    tick();
    checkOutput("rst_regWrite", 32'(bus.RegWrite), 32'd0);
    checkOutput("rst_lqCount", 32'(bus.lq_count), 32'd0);
    checkOutput("rst_luReadyLow", 32'(bus.lu_ready), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("rst_luReadyHigh", 32'(bus.lu_ready), 32'd1);

    // 1: single ALU write, one-cycle latency, then idle
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectWrite(5'd5, 32'hDEADBEEF);
    tick();
    checkOutput("t1_regWrite", 32'(bus.RegWrite), 32'd1);
    applyIdle();
    tick();
    checkOutput("t1_idle", 32'(bus.RegWrite), 32'd0);

    // 2: fill the FIFO while the ALU holds the write port
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 5'd10, 32'h100 + 32'(k), 1'b1, 5'(k), 32'hA0 + 32'(k), 1'b0, 5'd0);
      expectWrite(5'd10, 32'h100 + 32'(k));
      tick();
    end
    checkOutput("t2_lqCountFull", 32'(bus.lq_count), 32'd4);
    checkOutput("t2_luReadyFull", 32'(bus.lu_ready), 32'd0);

    // 3: full + pop refuses the push; next cycle push and pop together
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hB6, 1'b0, 5'd0);
    for (int k = 1; k <= 4; k++) begin
      expectWrite(5'(k), 32'hA0 + 32'(k));
    end
    expectWrite(5'd6, 32'hB6);
    tick();
    checkOutput("t3_noPushWhenFull", 32'(bus.lq_count), 32'd3);
    checkOutput("t3_luReadyAfterPop", 32'(bus.lu_ready), 32'd1);
    tick();
    checkOutput("t3_pushPopCount", 32'(bus.lq_count), 32'd3);
    applyIdle();
    tick();
    tick();
    tick();
    checkOutput("t3_drained", 32'(bus.lq_count), 32'd0);

    // 4: ALU to r0 lets the FIFO pop; LU handshake to r0 is consumed silently
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    tick();
    checkOutput("t4_oneQueued", 32'(bus.lq_count), 32'd1);
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectWrite(5'd7, 32'h77);
    tick();
    checkOutput("t4_aluAddr0Yields", 32'(bus.WriteAddr), 32'd7);
    applyStimulus(1'b1, 5'd12, 32'hC1, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0);
    expectWrite(5'd12, 32'hC1);
    tick();
    applyStimulus(1'b1, 5'd12, 32'hC2, 1'b1, 5'd0, 32'h99, 1'b0, 5'd0);
    expectWrite(5'd12, 32'hC2);
    tick();
    checkOutput("t4_luAddr0NotQueued", 32'(bus.lq_count), 32'd1);
    applyIdle();
    expectWrite(5'd8, 32'h88);
    tick();
    checkOutput("t4_drained", 32'(bus.lq_count), 32'd0);

    // 5: scoreboard set, hold through commit, clear after, re-mark wins
    bus.query_rs = 5'd9;
    bus.query_rt = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    tick();
    checkOutput("t5_addr0NeverBusy", 32'(bus.rt_busy), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    bus.query_rt = 5'd9;
    tick();
    checkOutput("t5_rsBusySet", 32'(bus.rs_busy), 32'd1);
    checkOutput("t5_rtBusySet", 32'(bus.rt_busy), 32'd1);
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectWrite(5'd9, 32'h99);
    tick();
    checkOutput("t5_busyDuringWrite", 32'(bus.rs_busy), 32'd1);
    applyIdle();
    tick();
    checkOutput("t5_clearedAfterWrite", 32'(bus.rs_busy), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    tick();
    applyStimulus(1'b1, 5'd9, 32'h9A, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectWrite(5'd9, 32'h9A);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    tick();
    checkOutput("t5_remarkWins", 32'(bus.rs_busy), 32'd1);
    applyIdle();
    tick();
    checkOutput("t5_stillPending", 32'(bus.rs_busy), 32'd1);
    applyStimulus(1'b1, 5'd9, 32'h9B, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectWrite(5'd9, 32'h9B);
    tick();
    applyIdle();
    tick();
    checkOutput("t5_finalClear", 32'(bus.rs_busy), 32'd0);

    // 6: reset mid-operation discards queued and in-flight writes
    bus.query_rs = 5'd20;
    applyStimulus(1'b1, 5'd13, 32'hD1, 1'b1, 5'd1, 32'h61, 1'b1, 5'd20);
    expectWrite(5'd13, 32'hD1);
    tick();
    applyStimulus(1'b1, 5'd13, 32'hD2, 1'b1, 5'd2, 32'h62, 1'b0, 5'd0);
    expectWrite(5'd13, 32'hD2);
    tick();
    applyStimulus(1'b1, 5'd13, 32'hD3, 1'b1, 5'd3, 32'h63, 1'b0, 5'd0);
    expectWrite(5'd13, 32'hD3);
    tick();
    checkOutput("t6_preResetCount", 32'(bus.lq_count), 32'd3);
    checkOutput("t6_preResetBusy", 32'(bus.rs_busy), 32'd1);
    reset = 1'b1;
    applyStimulus(1'b1, 5'd14, 32'hE1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    checkOutput("t6_regWriteCleared", 32'(bus.RegWrite), 32'd0);
    checkOutput("t6_lqCountCleared", 32'(bus.lq_count), 32'd0);
    checkOutput("t6_busyCleared", 32'(bus.rs_busy), 32'd0);
    checkOutput("t6_luReadyInReset", 32'(bus.lu_ready), 32'd0);
    reset = 1'b0;
    applyIdle();
    tick();
    tick();
    checkOutput("t6_postResetCount", 32'(bus.lq_count), 32'd0);
    checkOutput("t6_postResetReady", 32'(bus.lu_ready), 32'd1);
    checkOutput("t6_postResetIdle", 32'(bus.RegWrite), 32'd0);

    tick();
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
